// File: rtl/wshb_rr_arbiter.sv
// wshb_rr_arbiter: two-master Wishbone round-robin arbiter with per-grant transfer quota
module wshb_rr_arbiter #(
  parameter int QUOTA = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_ms,
  input  logic [3:0]  m0_sel,
  input  logic [2:0]  m0_cti,
  input  logic [1:0]  m0_bte,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  output logic [31:0] m0_dat_sm,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_ms,
  input  logic [3:0]  m1_sel,
  input  logic [2:0]  m1_cti,
  input  logic [1:0]  m1_bte,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  output logic [31:0] m1_dat_sm,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_ms,
  output logic [3:0]  s_sel,
  output logic [2:0]  s_cti,
  output logic [1:0]  s_bte,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_rty,
  input  logic [31:0] s_dat_sm
);
  localparam int cw = $clog2(QUOTA + 1);
  localparam logic [cw-1:0] quota_max = cw'(QUOTA);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nx;
  logic last_grant;
  logic [cw-1:0] cnt;
  logic gnt1, own_cyc, oth_cyc, term, yield, act;
  // grant decode, quota preemption and next-state selection
  always_comb begin
    gnt1 = state == GNT1;
    own_cyc = gnt1 ? m1_cyc : m0_cyc;
    oth_cyc = gnt1 ? m0_cyc : m1_cyc;
    term = s_ack | s_err | s_rty;
    yield = cnt == quota_max && oth_cyc;
    act = state != IDLE && !yield && !sys_rst;
    state_nx = state == IDLE ? (m0_cyc && m1_cyc ? (last_grant ? GNT0 : GNT1) :
                                m0_cyc ? GNT0 : m1_cyc ? GNT1 : IDLE) :
               (!own_cyc || yield) ? IDLE : state;
  end
  assign s_cyc = act && own_cyc;
  assign s_stb = act && (gnt1 ? m1_stb : m0_stb);
  assign s_we = gnt1 ? m1_we : m0_we;
  assign s_adr = gnt1 ? m1_adr : m0_adr;
  assign s_dat_ms = gnt1 ? m1_dat_ms : m0_dat_ms;
  assign s_sel = gnt1 ? m1_sel : m0_sel;
  assign s_cti = gnt1 ? m1_cti : m0_cti;
  assign s_bte = gnt1 ? m1_bte : m0_bte;
  assign m0_ack = act && !gnt1 && s_ack;
  assign m0_err = act && !gnt1 && s_err;
  assign m0_rty = act && !gnt1 && s_rty;
  assign m1_ack = act && gnt1 && s_ack;
  assign m1_err = act && gnt1 && s_err;
  assign m1_rty = act && gnt1 && s_rty;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  // state, quota counter (zero while idle, rearmed when quota lapses uncontested) and last grant
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= state == IDLE ? '0 : cnt == quota_max ? cw'(term) : cnt + cw'(term);
      if (state == IDLE && state_nx != IDLE) last_grant <= state_nx == GNT1;
    end
  end
endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// tb_wshb_rr_arbiter: directed scenarios plus randomized run against a behavioural arbiter model
module tb_wshb_rr_arbiter;
  localparam int quota = 4;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic m0_cyc, m0_stb, m0_we, m0_ack, m0_err, m0_rty;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
  logic [3:0] m0_sel;
  logic [2:0] m0_cti;
  logic [1:0] m0_bte;
  logic m1_cyc, m1_stb, m1_we, m1_ack, m1_err, m1_rty;
  logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0] m1_sel;
  logic [2:0] m1_cti;
  logic [1:0] m1_bte;
  logic s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0] s_sel;
  logic [2:0] s_cti;
  logic [1:0] s_bte;
  logic ack_en, err_en, rty_en, ack_force;
  int vectors = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  // slave that answers whatever strobe reaches it
  assign s_ack = ack_force | (ack_en & s_cyc & s_stb);
  assign s_err = err_en & s_cyc & s_stb;
  assign s_rty = rty_en & s_cyc & s_stb;

  wshb_rr_arbiter #(.QUOTA(quota)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms),
    .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms),
    .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack), .s_err(s_err),
    .s_rty(s_rty), .s_dat_sm(s_dat_sm)
  );

  task tick;
    @(posedge sys_clk);
    #1;
  endtask

  task clear;
    {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel, m0_cti, m0_bte} = '0;
    {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte} = '0;
    s_dat_sm = '0;
    {ack_en, err_en, rty_en, ack_force} = '0;
  endtask

  task test_reset;
    clear;
    sys_rst = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; ack_force = 1'b1;
    tick;
    tick;
    vectors++;
    if ({s_cyc, s_stb} !== 2'b00) begin
      miscompares++; $display("FAIL reset_bus got %b exp 00", {s_cyc, s_stb});
    end
    vectors++;
    if ({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !== 6'b0) begin
      miscompares++; $display("FAIL reset_term got %b exp 000000", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty});
    end
    vectors++;
    if ($isunknown({s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte, m0_dat_sm, m1_dat_sm})) begin
      miscompares++; $display("FAIL reset_no_x got adr %h exp known", s_adr);
    end
    sys_rst = 1'b0;
    #1;
    vectors++;
    if ({s_cyc, m0_ack, m1_ack} !== 3'b000) begin
      miscompares++; $display("FAIL post_reset got %b exp 000", {s_cyc, m0_ack, m1_ack});
    end
    clear;
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
  endtask

  task test_single_grant;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
    #1;
    vectors++;
    if (s_cyc !== 1'b0) begin
      miscompares++; $display("FAIL latency_idle got %b exp 0", s_cyc);
    end
    tick;
    vectors++;
    if ({s_cyc, s_stb, s_adr} !== {2'b11, 32'h100}) begin
      miscompares++; $display("FAIL single_grant got %b %b %h exp 1 1 00000100", s_cyc, s_stb, s_adr);
    end
    ack_en = 1'b1;
    #1;
    vectors++;
    if ({m0_ack, m1_ack} !== 2'b10) begin
      miscompares++; $display("FAIL single_ack got %b exp 10", {m0_ack, m1_ack});
    end
    clear;
    tick;
    vectors++;
    if (s_cyc !== 1'b0) begin
      miscompares++; $display("FAIL single_release got %b exp 0", s_cyc);
    end
    tick;
  endtask

  task test_tie;
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h10;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h20;
    ack_en = 1'b1;
    tick;
    vectors++;
    if ({s_cyc, s_adr, m0_ack, m1_ack} !== {1'b1, 32'h10, 2'b10}) begin
      miscompares++; $display("FAIL tie_first got cyc %b adr %h acks %b%b exp 1 00000010 10", s_cyc, s_adr, m0_ack, m1_ack);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick;
    vectors++;
    if ({s_cyc, m0_ack, m1_ack} !== 3'b000) begin
      miscompares++; $display("FAIL tie_gap got %b exp 000", {s_cyc, m0_ack, m1_ack});
    end
    tick;
    vectors++;
    if ({s_cyc, s_adr, m0_ack, m1_ack} !== {1'b1, 32'h20, 2'b01}) begin
      miscompares++; $display("FAIL tie_second got cyc %b adr %h acks %b%b exp 1 00000020 01", s_cyc, s_adr, m0_ack, m1_ack);
    end
    clear;
    tick;
    tick;
  endtask

  task test_quota_preempt;
    logic [11:0] e_cyc, e_m0, e_m1;
    e_cyc = 12'h99E;
    e_m0 = 12'h81E;
    e_m1 = 12'h180;
    m0_adr = 32'hA0; m1_adr = 32'hB0;
    for (int k = 0; k < 12; k++) begin
      m0_cyc = 1'b1; m0_stb = 1'b1;
      m1_cyc = k < 9; m1_stb = k < 9;
      ack_en = 1'b1;
      #1;
      vectors++;
      if ({s_cyc, m0_ack, m1_ack} !== {e_cyc[k], e_m0[k], e_m1[k]}) begin
        miscompares++; $display("FAIL quota_cycle%0d got %b exp %b", k, {s_cyc, m0_ack, m1_ack}, {e_cyc[k], e_m0[k], e_m1[k]});
      end
      if (k == 7) begin
        vectors++;
        if (s_adr !== 32'hB0) begin
          miscompares++; $display("FAIL quota_handover_adr got %h exp 000000b0", s_adr);
        end
      end
      tick;
    end
    clear;
    tick;
    tick;
  endtask

  task test_alone_no_gap;
    int acks;
    acks = 0;
    for (int k = 0; k < 11; k++) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; ack_en = 1'b1;
      #1;
      acks += int'(m0_ack);
      vectors++;
      if ({s_cyc, m0_ack} !== {2{k != 0}}) begin
        miscompares++; $display("FAIL alone_cycle%0d got %b exp %b", k, {s_cyc, m0_ack}, {2{k != 0}});
      end
      tick;
    end
    vectors++;
    if (acks !== 10) begin
      miscompares++; $display("FAIL alone_ack_count got %0d exp 10", acks);
    end
    clear;
    tick;
    tick;
  endtask

  task test_read_broadcast;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; ack_en = 1'b1;
    s_dat_sm = 32'hDEADBEEF;
    tick;
    vectors++;
    if ({m1_dat_sm, m1_ack, m0_ack} !== {32'hDEADBEEF, 2'b10}) begin
      miscompares++; $display("FAIL read_m1 got %h ack %b%b exp deadbeef 10", m1_dat_sm, m1_ack, m0_ack);
    end
    vectors++;
    if (m0_dat_sm !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL read_broadcast got %h exp deadbeef", m0_dat_sm);
    end
    clear;
    tick;
    tick;
  endtask

  task test_reset_mid_burst;
    m1_cyc = 1'b1; m1_stb = 1'b1; ack_en = 1'b1;
    tick;
    tick;
    vectors++;
    if (m1_ack !== 1'b1) begin
      miscompares++; $display("FAIL midrst_burst got %b exp 1", m1_ack);
    end
    sys_rst = 1'b1; ack_force = 1'b1;
    #1;
    vectors++;
    if ({s_cyc, m1_ack, m0_ack} !== 3'b000) begin
      miscompares++; $display("FAIL midrst_during got %b exp 000", {s_cyc, m1_ack, m0_ack});
    end
    tick;
    sys_rst = 1'b0;
    #1;
    vectors++;
    if ({s_cyc, m1_ack, m0_ack} !== 3'b000) begin
      miscompares++; $display("FAIL midrst_after got %b exp 000", {s_cyc, m1_ack, m0_ack});
    end
    clear;
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
  endtask

  task test_random;
    int owner, served, last, kind, t;
    logic yield, oc, ostb, xc, e_cyc, e_stb, e_a, e_e, e_r;
    logic [73:0] e_bus;
    owner = -1; served = 0; last = 1;
    for (int n = 0; n < 400; n++) begin
      m0_cyc = m0_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
      m1_cyc = m1_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
      m0_stb = m0_cyc & ($urandom_range(3) != 0);
      m1_stb = m1_cyc & ($urandom_range(3) != 0);
      {m0_we, m1_we} = 2'($urandom);
      m0_adr = $urandom; m1_adr = $urandom; m0_dat_ms = $urandom; m1_dat_ms = $urandom;
      {m0_sel, m0_cti, m0_bte} = 9'($urandom);
      {m1_sel, m1_cti, m1_bte} = 9'($urandom);
      s_dat_sm = $urandom;
      kind = $urandom_range(3);
      ack_en = kind == 1; err_en = kind == 2; rty_en = kind == 3;
      #1;
      oc = owner == 1 ? m1_cyc : m0_cyc;
      ostb = owner == 1 ? m1_stb : m0_stb;
      xc = owner == 1 ? m0_cyc : m1_cyc;
      yield = owner >= 0 && served == quota && xc;
      e_cyc = owner >= 0 && !yield && oc;
      e_stb = owner >= 0 && !yield && ostb;
      e_a = e_cyc & e_stb & ack_en;
      e_e = e_cyc & e_stb & err_en;
      e_r = e_cyc & e_stb & rty_en;
      vectors++;
      if ({s_cyc, s_stb, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !==
          {e_cyc, e_stb, owner == 0 ? {e_a, e_e, e_r} : 3'b0, owner == 1 ? {e_a, e_e, e_r} : 3'b0}) begin
        miscompares++;
        $display("FAIL rand%0d_ctrl got %b exp %b", n, {s_cyc, s_stb, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty},
                 {e_cyc, e_stb, owner == 0 ? {e_a, e_e, e_r} : 3'b0, owner == 1 ? {e_a, e_e, e_r} : 3'b0});
      end
      e_bus = owner == 1 ? {m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte, m1_we} : {m0_adr, m0_dat_ms, m0_sel, m0_cti, m0_bte, m0_we};
      if (e_cyc) begin
        vectors++;
        if ({s_adr, s_dat_ms, s_sel, s_cti, s_bte, s_we} !== e_bus) begin
          miscompares++; $display("FAIL rand%0d_bus got %h exp %h", n, {s_adr, s_dat_ms, s_sel, s_cti, s_bte, s_we}, e_bus);
        end
      end
      vectors++;
      if ({m0_dat_sm, m1_dat_sm} !== {s_dat_sm, s_dat_sm}) begin
        miscompares++; $display("FAIL rand%0d_rdata got %h %h exp %h", n, m0_dat_sm, m1_dat_sm, s_dat_sm);
      end
      t = int'(e_a | e_e | e_r);
      if (owner < 0) begin
        owner = (m0_cyc && m1_cyc) ? (last == 1 ? 0 : 1) : m0_cyc ? 0 : m1_cyc ? 1 : -1;
        if (owner >= 0) begin
          served = 0;
          last = owner;
        end
      end else if (!oc || yield) owner = -1;
      else served = served == quota ? t : served + t;
      tick;
    end
    clear;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_grant;
    test_tie;
    test_quota_preempt;
    test_alone_no_gap;
    test_read_broadcast;
    test_reset_mid_burst;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
